// File: rtl/energy_ctrl_pkg.sv
// Shared types and default sizing for the sliding-window energy sequencer.
package energy_ctrl_pkg;

    localparam int DEF_WINDOW_LOG2  = 4;
    localparam int DEF_SAMPLE_W     = 16;
    localparam int DEF_ENERGY_W     = 64;
    localparam int DET_HOLD_COUNT   = 4;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/energy_window_buf.sv
// Circular sample store for the energy window; the slot at the write pointer
// is read combinationally so the caller sees the outgoing sample before it is overwritten.
module energy_window_buf
    import energy_ctrl_pkg::*;
#(
    parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
    parameter int SAMPLE_W    = DEF_SAMPLE_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_clear,
    input  logic                i_wr_en,
    input  logic [SAMPLE_W-1:0] i_wr_data,
    output logic [SAMPLE_W-1:0] o_rd_data
);

    localparam int N = 1 << WINDOW_LOG2;

    logic [SAMPLE_W-1:0]    r_mem [N];
    logic [WINDOW_LOG2-1:0] r_wr_ptr;

    // Write pointer wraps naturally at N
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + WINDOW_LOG2'(1);
        end else begin
            r_wr_ptr <= r_wr_ptr;
        end
    end

    // Contents need no reset: stale data is masked while priming
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_wr_ptr];

endmodule

// File: rtl/energy_window_ctrl.sv
// Sequencer feeding first/last operands to one signalEnergy datapath.
// Optional threshold detector with hysteresis is built when ENERGY_DETECT_EN is defined.
module energy_window_ctrl
    import energy_ctrl_pkg::*;
#(
    parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int ENERGY_W    = DEF_ENERGY_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_clear,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [SAMPLE_W-1:0] i_in_sample,
    output logic                o_dp_reset,
    output logic [SAMPLE_W-1:0] o_dp_first,
    output logic [SAMPLE_W-1:0] o_dp_last,
    input  logic [ENERGY_W-1:0] i_dp_energy,
    output logic [ENERGY_W-1:0] o_energy_out,
    output logic                o_energy_valid,
    output logic                o_primed
`ifdef ENERGY_DETECT_EN
    ,
    input  logic [ENERGY_W-1:0] i_det_threshold,
    output logic                o_det_flag
`endif
);

    localparam int N      = 1 << WINDOW_LOG2;
    localparam int FILL_W = WINDOW_LOG2 + 1;

    ctrl_state_e         r_state;
    ctrl_state_e         w_state_next;
    logic [FILL_W-1:0]   r_fill;
    logic                w_accept;
    logic                w_full_after;
    logic [SAMPLE_W-1:0] w_rd_data;
    logic [SAMPLE_W-1:0] r_dp_first;
    logic [SAMPLE_W-1:0] r_dp_last;
    logic                r_stb1;
    logic                r_tag1;
    logic                r_stb2;
    logic                r_tag2;
    logic                r_energy_valid;

    assign o_in_ready   = (r_state != FLUSH) && !i_clear;
    assign w_accept     = i_in_valid && o_in_ready;
    assign o_dp_reset   = reset || (r_state == FLUSH);
    // Window is full once this accept lands, counting the incoming sample
    assign w_full_after = (r_fill == FILL_W'(N - 1)) || (r_fill == FILL_W'(N));

    energy_window_buf #(
        .WINDOW_LOG2 (WINDOW_LOG2),
        .SAMPLE_W    (SAMPLE_W)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (i_clear),
        .i_wr_en   (w_accept),
        .i_wr_data (i_in_sample),
        .o_rd_data (w_rd_data)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= FLUSH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = FLUSH;
        end else begin
            case (r_state)
                FLUSH:   w_state_next = PRIME;
                PRIME:   w_state_next = (w_accept && w_full_after) ? RUN : PRIME;
                RUN:     w_state_next = RUN;
                default: w_state_next = FLUSH;
            endcase
        end
    end

    // Fill counter saturating at N
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_fill <= '0;
        end else if (w_accept && (r_fill != FILL_W'(N))) begin
            r_fill <= r_fill + FILL_W'(1);
        end else begin
            r_fill <= r_fill;
        end
    end

    // Operands are live for exactly one cycle per accept, zero otherwise
    always_ff @(posedge clock) begin
        if (reset || i_clear || !w_accept) begin
            r_dp_first <= '0;
            r_dp_last  <= '0;
        end else begin
            r_dp_first <= i_in_sample;
            r_dp_last  <= (r_state == RUN) ? w_rd_data : '0;
        end
    end

    // Strobe follows the sample through temp and energy stages of the datapath
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_stb1         <= 1'b0;
            r_tag1         <= 1'b0;
            r_stb2         <= 1'b0;
            r_tag2         <= 1'b0;
            r_energy_valid <= 1'b0;
        end else begin
            r_stb1         <= w_accept;
            r_tag1         <= w_accept && w_full_after;
            r_stb2         <= r_stb1;
            r_tag2         <= r_tag1;
            r_energy_valid <= r_stb2 && r_tag2;
        end
    end

    assign o_dp_first     = r_dp_first;
    assign o_dp_last      = r_dp_last;
    assign o_energy_out   = i_dp_energy;
    assign o_energy_valid = r_energy_valid;
    assign o_primed       = (r_state == RUN);

`ifdef ENERGY_DETECT_EN
    logic [2:0] r_det_cnt;
    logic       r_det_flag;
    logic       w_det_hi;
    logic       w_det_lo;

    assign w_det_hi = $signed(i_dp_energy) >= $signed(i_det_threshold);
    assign w_det_lo = $signed(i_dp_energy) < ($signed(i_det_threshold) >>> 1);

    // Set after a run of high windows, released only well below threshold
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_det_cnt  <= 3'd0;
            r_det_flag <= 1'b0;
        end else if (r_energy_valid) begin
            if (w_det_hi) begin
                r_det_cnt  <= (r_det_cnt == 3'(DET_HOLD_COUNT)) ? r_det_cnt : r_det_cnt + 3'd1;
                r_det_flag <= (r_det_cnt >= 3'(DET_HOLD_COUNT - 1)) ? 1'b1 : r_det_flag;
            end else begin
                r_det_cnt  <= 3'd0;
                r_det_flag <= w_det_lo ? 1'b0 : r_det_flag;
            end
        end else begin
            r_det_cnt  <= r_det_cnt;
            r_det_flag <= r_det_flag;
        end
    end

    assign o_det_flag = r_det_flag;
`endif

endmodule

// File: tb/tb_energy_window_ctrl.sv
// Directed bench for energy_window_ctrl with a behavioural signalEnergy model.
module tb_energy_window_ctrl;

    localparam int SW = 16;
    localparam int EW = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_sample;
    logic          dp_reset;
    logic [SW-1:0] dp_first;
    logic [SW-1:0] dp_last;
    logic [EW-1:0] dp_energy;
    logic [EW-1:0] energy_out;
    logic          energy_valid;
    logic          primed;
`ifdef ENERGY_DETECT_EN
    logic [EW-1:0] det_threshold;
    logic          det_flag;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    energy_window_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .i_clear        (clear),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_sample    (in_sample),
        .o_dp_reset     (dp_reset),
        .o_dp_first     (dp_first),
        .o_dp_last      (dp_last),
        .i_dp_energy    (dp_energy),
        .o_energy_out   (energy_out),
        .o_energy_valid (energy_valid),
        .o_primed       (primed)
`ifdef ENERGY_DETECT_EN
        ,
        .i_det_threshold(det_threshold),
        .o_det_flag     (det_flag)
`endif
    );

    // signalEnergy model: temp = first^2 - last^2, energy += temp / N
    logic signed [EW-1:0] m_f, m_l, m_temp, m_energy;
    assign m_f = $signed(dp_first);
    assign m_l = $signed(dp_last);
    always_ff @(posedge clock) begin
        if (dp_reset) begin
            m_temp   <= 64'sd0;
            m_energy <= 64'sd0;
        end else begin
            m_temp   <= m_f * m_f - m_l * m_l;
            m_energy <= m_energy + (m_temp >>> 4);
        end
    end
    assign dp_energy = m_energy;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sample = 16'd0;
        step(); step();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (dp_reset !== 1'b1) $display("FAIL rst_dp_reset got %b exp 1", dp_reset); else n_pass++;
        n_checks++; if ({dp_first, dp_last} !== 32'd0) $display("FAIL rst_operands got %h/%h exp 0/0", dp_first, dp_last); else n_pass++;
        n_checks++; if (energy_valid !== 1'b0) $display("FAIL rst_energy_valid got %b exp 0", energy_valid); else n_pass++;
        n_checks++; if (primed !== 1'b0) $display("FAIL rst_primed got %b exp 0", primed); else n_pass++;
        n_checks++; if (energy_out !== 64'd0) $display("FAIL rst_energy_out got %0d exp 0", energy_out); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if ({in_ready, dp_reset} !== 2'b01) $display("FAIL flush_cycle got ready=%b dp_reset=%b exp 0/1", in_ready, dp_reset); else n_pass++;
        step();
        n_checks++; if ({in_ready, dp_reset} !== 2'b10) $display("FAIL after_flush got ready=%b dp_reset=%b exp 1/0", in_ready, dp_reset); else n_pass++;
    endtask

    // 16 back-to-back accepts from an empty window, then the first valid pulse
    task automatic fill16(input logic [SW-1:0] v, input logic [EW-1:0] exp_e);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_sample = v;
            step();
            n_checks++; if ({dp_first, dp_last} !== {v, 16'd0}) $display("FAIL fill_operands[%0d] got %0d/%0d exp %0d/0", i, dp_first, dp_last, v); else n_pass++;
            n_checks++; if (energy_valid !== 1'b0) $display("FAIL fill_no_valid[%0d] got %b exp 0", i, energy_valid); else n_pass++;
            n_checks++; if (primed !== (i == 15)) $display("FAIL fill_primed[%0d] got %b exp %b", i, primed, (i == 15)); else n_pass++;
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (energy_valid !== 1'b0) $display("FAIL fill_edge1_valid got %b exp 0", energy_valid); else n_pass++;
        step();
        n_checks++; if (energy_valid !== 1'b1) $display("FAIL fill_edge2_valid got %b exp 1", energy_valid); else n_pass++;
        n_checks++; if (energy_out !== exp_e) $display("FAIL fill_energy got %0d exp %0d", energy_out, exp_e); else n_pass++;
        step();
        n_checks++; if (energy_valid !== 1'b0) $display("FAIL fill_single_pulse got %b exp 0", energy_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_sample = 16'd4;
            step();
            n_checks++; if ({dp_first, dp_last} !== {16'd4, 16'd4}) $display("FAIL b2b_operands[%0d] got %0d/%0d exp 4/4", i, dp_first, dp_last); else n_pass++;
            n_checks++; if (energy_valid !== (i >= 2)) $display("FAIL b2b_valid[%0d] got %b exp %b", i, energy_valid, (i >= 2)); else n_pass++;
            n_checks++; if (energy_out !== 64'd16) $display("FAIL b2b_energy[%0d] got %0d exp 16", i, energy_out); else n_pass++;
        end
        in_valid = 1'b0;
        step(); step();
        n_checks++; if (energy_valid !== 1'b1) $display("FAIL b2b_tail_valid got %b exp 1", energy_valid); else n_pass++;
        step();
        n_checks++; if (energy_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", energy_valid); else n_pass++;
    endtask

    task automatic test_step8();
        in_valid = 1'b1; in_sample = 16'd8;
        step();
        n_checks++; if ({dp_first, dp_last} !== {16'd8, 16'd4}) $display("FAIL step8_operands got %0d/%0d exp 8/4", dp_first, dp_last); else n_pass++;
        in_valid = 1'b0;
        step(); step();
        n_checks++; if (energy_valid !== 1'b1) $display("FAIL step8_valid got %b exp 1", energy_valid); else n_pass++;
        n_checks++; if (energy_out !== 64'd19) $display("FAIL step8_energy got %0d exp 19", energy_out); else n_pass++;
        step();
    endtask

    task automatic test_clear();
        in_valid = 1'b1; in_sample = 16'd4;
        step(); step();
        clear = 1'b1; in_sample = 16'd100;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL clear_ready got %b exp 0", in_ready); else n_pass++;
        step();
        n_checks++; if ({dp_first, dp_last} !== 32'd0) $display("FAIL clear_dropped got %0d/%0d exp 0/0", dp_first, dp_last); else n_pass++;
        n_checks++; if ({dp_reset, primed, energy_valid} !== 3'b100) $display("FAIL clear_flush got rst=%b primed=%b valid=%b exp 1/0/0", dp_reset, primed, energy_valid); else n_pass++;
        clear = 1'b0; in_valid = 1'b0;
        step();
        n_checks++; if (energy_valid !== 1'b0) $display("FAIL clear_squash1 got %b exp 0", energy_valid); else n_pass++;
        n_checks++; if (energy_out !== 64'd0) $display("FAIL clear_energy got %0d exp 0", energy_out); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL clear_ready_back got %b exp 1", in_ready); else n_pass++;
        step();
        n_checks++; if (energy_valid !== 1'b0) $display("FAIL clear_squash2 got %b exp 0", energy_valid); else n_pass++;
        fill16(16'd4, 64'd16);
    endtask

`ifdef ENERGY_DETECT_EN
    task automatic test_detect();
        logic acc [25];
        logic e_valid;
        logic e_flag;
        int   e_cnt;
        e_flag = 1'b0; e_cnt = 0;
        det_threshold = 64'd16;
        for (int t = 0; t < 25; t++) begin
            in_valid  = (t < 22);
            in_sample = (t < 8) ? 16'd4 : 16'd0;
            acc[t]    = in_valid;
            step();
            e_valid = (t >= 2) ? acc[t-2] : 1'b0;
            n_checks++; if (energy_valid !== e_valid) $display("FAIL det_valid[%0d] got %b exp %b", t, energy_valid, e_valid); else n_pass++;
            n_checks++; if (det_flag !== e_flag) $display("FAIL det_flag[%0d] got %b exp %b", t, det_flag, e_flag); else n_pass++;
            if (e_valid) begin
                if (m_energy >= 64'sd16) begin
                    e_cnt++;
                    if (e_cnt >= 4) e_flag = 1'b1;
                end else begin
                    e_cnt = 0;
                    if (m_energy < 64'sd8) e_flag = 1'b0;
                end
            end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef ENERGY_DETECT_EN
        det_threshold = 64'h7fff_ffff_ffff_ffff;
`endif
        test_reset();
        fill16(16'd4, 64'd16);
        test_back_to_back();
        test_step8();
        test_clear();
`ifdef ENERGY_DETECT_EN
        test_detect();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
